// File: rtl/spi_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : spi_frame_loader
//  Purpose  : Frames the SPI byte stream into 1- or 4-byte commands and
//             drives the LED-matrix frame-buffer write port. It also returns
//             a status byte to the SPI slave.
//  Ports    : clk, reset        system clock, async active-high reset
//             sck               raw SPI clock (asynchronous to clk)
//             rx_byte[7:0]      SPI slave receive shift register
//             tx_byte[7:0]      status {busy, err, ovr, 0, last_op[3:0]}
//             fb_we/fb_addr/fb_wdata  frame-buffer write port
//             frame_swap        one-clk back-buffer commit pulse
//             busy              clear in progress
//             err               sticky bad-opcode / out-of-range flag
//  Revision : 1.0  initial release
// ============================================================================
module spi_frame_loader #(
  parameter int ROW_BITS = 5,
  parameter int COL_BITS = 5,
  parameter int TIMEOUT  = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sck,
  input  logic [7:0]                   rx_byte,
  output logic [7:0]                   tx_byte,
  output logic                         fb_we,
  output logic [ROW_BITS+COL_BITS-1:0] fb_addr,
  output logic [2:0]                   fb_wdata,
  output logic                         frame_swap,
  output logic                         busy,
  output logic                         err
);

  localparam int ADDR_BITS = ROW_BITS + COL_BITS;
  localparam int IDLE_BITS = $clog2(TIMEOUT + 1);

  localparam logic [IDLE_BITS-1:0] C_TIMEOUT   = IDLE_BITS'(TIMEOUT);
  localparam logic [ADDR_BITS-1:0] C_LAST_ADDR = '1;
  localparam logic [7:0]           C_OP_PIXEL  = 8'h01;
  localparam logic [7:0]           C_OP_CLEAR  = 8'h02;
  localparam logic [7:0]           C_OP_SWAP   = 8'h03;
  localparam logic [7:0]           C_OP_CLRERR = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ROW   = 3'd1,
    S_COL   = 3'd2,
    S_COLOR = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic                 sck_meta_q,   sck_meta_d;
  logic                 sck_sync_q,   sck_sync_d;
  logic                 sck_prev_q,   sck_prev_d;
  logic [2:0]           bit_cnt_q,    bit_cnt_d;
  logic [IDLE_BITS-1:0] idle_q,       idle_d;
  state_t               state_q,      state_d;
  logic [7:0]           row_q,        row_d;
  logic [7:0]           col_q,        col_d;
  logic                 fb_we_q,      fb_we_d;
  logic [ADDR_BITS-1:0] fb_addr_q,    fb_addr_d;
  logic [2:0]           fb_wdata_q,   fb_wdata_d;
  logic                 frame_swap_q, frame_swap_d;
  logic                 busy_q,       busy_d;
  logic                 err_q,        err_d;
  logic                 ovr_q,        ovr_d;
  logic [3:0]           last_op_q,    last_op_d;
  logic [7:0]           tx_byte_q,    tx_byte_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic       w_rise;
  logic       w_byte_v;
  logic [7:0] w_byte;
  logic       w_timeout;
  state_t     w_state;
  logic       w_row_bad;
  logic       w_col_bad;

  // sck synchronizer, edge detect, bit counter and idle counter.
  always_comb begin
    sck_meta_d = sck;
    sck_sync_d = sck_meta_q;
    sck_prev_d = sck_sync_q;

    w_rise   = sck_sync_q & ~sck_prev_q;
    // The 8th rise of a byte completes it; rx_byte is stable around here.
    w_byte_v = w_rise && (bit_cnt_q == 3'd7);
    w_byte   = rx_byte;

    bit_cnt_d = w_rise ? (bit_cnt_q + 3'd1) : bit_cnt_q;

    // Saturating count of clks since the last sck rise.
    if (w_rise) begin
      idle_d = '0;
    end else if (idle_q != C_TIMEOUT) begin
      idle_d = idle_q + IDLE_BITS'(1);
    end else begin
      idle_d = idle_q;
    end

    // An expired partial packet is treated as if the FSM were already idle,
    // so a byte arriving on the same clk is decoded as a fresh opcode.
    w_timeout = (idle_q == C_TIMEOUT) &&
                ((state_q == S_ROW) || (state_q == S_COL) || (state_q == S_COLOR));
    w_state   = w_timeout ? S_IDLE : state_q;

    w_row_bad = (row_q >> ROW_BITS) != 8'd0;
    w_col_bad = (col_q >> COL_BITS) != 8'd0;
  end

  // Command FSM: next state and outputs.
  always_comb begin
    state_d      = w_state;
    row_d        = row_q;
    col_d        = col_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_wdata_d   = fb_wdata_q;
    frame_swap_d = 1'b0;
    busy_d       = busy_q;
    err_d        = err_q;
    ovr_d        = ovr_q;
    last_op_d    = last_op_q;

    case (w_state)
      S_IDLE: begin
        if (w_byte_v) begin
          case (w_byte)
            C_OP_PIXEL: begin
              last_op_d = 4'h1;
              state_d   = S_ROW;
            end
            C_OP_CLEAR: begin
              // First clear write is issued on entry; fb_addr doubles as
              // the clear address counter.
              last_op_d  = 4'h2;
              state_d    = S_CLEAR;
              busy_d     = 1'b1;
              fb_we_d    = 1'b1;
              fb_addr_d  = '0;
              fb_wdata_d = 3'b000;
            end
            C_OP_SWAP: begin
              last_op_d    = 4'h3;
              frame_swap_d = 1'b1;
            end
            C_OP_CLRERR: begin
              last_op_d = 4'h4;
              err_d     = 1'b0;
              ovr_d     = 1'b0;
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end
      end

      S_ROW: begin
        if (w_byte_v) begin
          row_d   = w_byte;
          state_d = S_COL;
        end
      end

      S_COL: begin
        if (w_byte_v) begin
          col_d   = w_byte;
          state_d = S_COLOR;
        end
      end

      S_COLOR: begin
        if (w_byte_v) begin
          state_d = S_IDLE;
          if (w_row_bad || w_col_bad) begin
            err_d = 1'b1;
          end else begin
            fb_we_d    = 1'b1;
            fb_addr_d  = {row_q[ROW_BITS-1:0], col_q[COL_BITS-1:0]};
            fb_wdata_d = w_byte[2:0];
          end
        end
      end

      S_CLEAR: begin
        if (w_byte_v) begin
          ovr_d = 1'b1;
        end
        if (fb_addr_q == C_LAST_ADDR) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          fb_we_d   = 1'b1;
          fb_addr_d = fb_addr_q + ADDR_BITS'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status byte trails the status flops by one clk.
    tx_byte_d = {busy_q, err_q, ovr_q, 1'b0, last_op_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_meta_q   <= 1'b0;
      sck_sync_q   <= 1'b0;
      sck_prev_q   <= 1'b0;
      bit_cnt_q    <= 3'd0;
      idle_q       <= '0;
      state_q      <= S_IDLE;
      row_q        <= 8'd0;
      col_q        <= 8'd0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= 3'b000;
      frame_swap_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      ovr_q        <= 1'b0;
      last_op_q    <= 4'h0;
      tx_byte_q    <= 8'h00;
    end else begin
      sck_meta_q   <= sck_meta_d;
      sck_sync_q   <= sck_sync_d;
      sck_prev_q   <= sck_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      idle_q       <= idle_d;
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
      frame_swap_q <= frame_swap_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      ovr_q        <= ovr_d;
      last_op_q    <= last_op_d;
      tx_byte_q    <= tx_byte_d;
    end
  end

  assign tx_byte    = tx_byte_q;
  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wdata   = fb_wdata_q;
  assign frame_swap = frame_swap_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: doc/spi_frame_loader.md
# spi_frame_loader

Consumes the byte stream produced by the Pi-to-FPGA SPI slave, frames it into 1- or 4-byte commands, and drives the write port of the LED-matrix frame buffer. It also returns a status byte to the SPI slave's transmit-data input. It sits between the SPI slave and the display frame buffer, in the system clock domain.

## Interface
Parameters:
- ROW_BITS, 5, row address width (32 rows)
- COL_BITS, 5, column address width (32 columns)
- TIMEOUT, 4096, idle clk cycles after which a partial packet is abandoned

Ports:
- clk  in  1  system clock; must be ≥ 8× sck frequency
- reset  in  1  reset, asynchronous, active-high; shared with the SPI slave so bit alignment matches
- sck  in  1  raw SPI clock from the Pi (asynchronous to clk)
- rx_byte  in  8  received-byte shift register from the SPI slave
- tx_byte  out  8  status byte to the SPI slave transmit-data input: {busy, err, ovr, 1'b0, last_op[3:0]}
- fb_we  out  1  frame-buffer write strobe
- fb_addr  out  ROW_BITS+COL_BITS  write address {row, col}
- fb_wdata  out  3  pixel colour {R,G,B}
- frame_swap  out  1  one-clk pulse: back buffer committed
- busy  out  1  clear sequence in progress
- err  out  1  sticky: bad opcode or out-of-range coordinate

## Operation
- sck passes through a 2-FF synchronizer, then a rising-edge detector. A 3-bit bit counter increments on each detected rise and resets only on reset.
- When a rise takes the bit counter from 7 to 0, rx_byte is captured into byte_r and byte_v pulses for one clk. rx_byte is stable for ≥ 4 clk around this point given the clock-ratio rule.
- Opcodes, interpreted from the first byte of a packet:
  - 0x01 PIXEL: three more bytes follow: row, col, colour[2:0]. The upper bits of colour are ignored.
  - 0x02 CLEAR: writes 0 to every address 0..2^(ROW_BITS+COL_BITS)-1, one per clk.
  - 0x03 SWAP: pulses frame_swap.
  - 0x04 CLRERR: clears err and ovr.
  - Any other opcode: sets err; the byte is discarded and the FSM stays in IDLE.
- FSM states: IDLE, ROW, COL, COLOR, CLEAR.
  - IDLE + byte_v with 0x01 → ROW.
  - ROW + byte_v → COL.
  - COL + byte_v → COLOR.
  - COLOR + byte_v → IDLE, issuing the write.
  - IDLE + 0x02 → CLEAR. CLEAR → IDLE after the last address is written.
- Range check: if row ≥ 2^ROW_BITS or col ≥ 2^COL_BITS, err is set and no write is issued. The packet is still consumed.
- Bytes arriving in CLEAR are dropped and set ovr (sticky). The clear runs to completion.
- last_op holds the low nibble of the most recently accepted opcode; reset value 0.
- Timeout: an idle counter resets on every sck rise. If it reaches TIMEOUT while in ROW, COL, or COLOR, the FSM returns to IDLE with no write. The bit counter is not affected.

## Timing
- Reset values: tx_byte=0x00, fb_we=0, fb_addr=0, fb_wdata=0, frame_swap=0, busy=0, err=0. Internally: FSM=IDLE, bit counter=0, ovr=0.
- sck rise to edge-detect pulse: 3 clk. The edge-detect pulse for the 8th rise produces byte_v on the same clk.
- PIXEL: fb_we=1 for exactly one clk, in the clk after the colour byte's byte_v, with fb_addr and fb_wdata valid on that same clk.
- SWAP: frame_swap=1 for one clk, in the clk after the opcode's byte_v.
- CLEAR:
  - busy rises the clk after byte_v.
  - fb_we is high continuously for 1024 clk (default parameters), with addresses incrementing from 0 and wdata=0.
  - busy falls on the clk after the last write.
- tx_byte is registered and updates the clk after any status change. The SPI slave samples it at the next byte boundary.
- Reset mid-packet or mid-clear: all state returns to reset values immediately. No further writes occur.
- byte_v coinciding with timeout expiry: the timeout takes priority and the byte is treated as a new opcode in IDLE.

## Test plan
- Send 0x01,0x05,0x1F,0x06 → one fb_we pulse, fb_addr=0x0BF, fb_wdata=3'b110, err=0, tx_byte[3:0]=1.
- Send 0x01,0x20,0x00,0x07 → no fb_we, err=1, tx_byte=0x41. Then send 0x04 → err=0, tx_byte=0x04.
- Send 0x02, then 0x03 during the clear → exactly 1024 writes of 0 at addresses 0..1023, busy high for 1024 clk, no frame_swap, ovr=1 (tx_byte bit 5).
- Send 0x03 → frame_swap high for exactly 1 clk; tx_byte[3:0]=3.
- Send 0x01,0x02, then stall for TIMEOUT clk, then send 0x03 → no fb_we, frame_swap pulses, err=0.
- Assert reset during a clear at address 300 → fb_we and busy drop immediately. A following 0x01,0,0,1 writes address 0 with colour 1.
